core_iencode: RTL and testbench

- RV32I instruction encoder and program loader: the encode side of the instruction decoder.
- Accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit RV32I words.
- Writes the words sequentially into instruction memory starting at a programmed base address.
- Used by the self-test/boot path to build programs in IMEM without an external assembler.

---
 rtl/core_iencode_if.sv | 39 +++
 rtl/core_iencode.sv | 206 ++++++++++++++++++++
 tb/tb_core_iencode.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_iencode_if.sv
// Field-set, memory-write and session-status signals of the RV32I encoder/loader.
// The slave modport is the encoder; the master modport is whoever feeds it and owns IMEM.
interface core_iencode_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              START;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [CNT_W-1:0]  COUNT;
  logic              IN_VALID;
  logic              IN_READY;
  logic [3:0]        OPCLASS;
  logic [2:0]        FUNCT3;
  logic [6:0]        FUNCT7;
  logic [4:0]        RD;
  logic [4:0]        RS1;
  logic [4:0]        RS2;
  logic [31:0]       IMM;
  logic              MEM_WVALID;
  logic              MEM_WREADY;
  logic [ADDR_W-1:0] MEM_WADDR;
  logic [31:0]       MEM_WDATA;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [CNT_W-1:0]  ERR_IDX;

  modport master (
    output START, BASE_ADDR, COUNT, IN_VALID, OPCLASS, FUNCT3, FUNCT7,
           RD, RS1, RS2, IMM, MEM_WREADY,
    input  IN_READY, MEM_WVALID, MEM_WADDR, MEM_WDATA, BUSY, DONE, ERR, ERR_IDX
  );

  modport slave (
    input  START, BASE_ADDR, COUNT, IN_VALID, OPCLASS, FUNCT3, FUNCT7,
           RD, RS1, RS2, IMM, MEM_WREADY,
    output IN_READY, MEM_WVALID, MEM_WADDR, MEM_WDATA, BUSY, DONE, ERR, ERR_IDX
  );
endinterface

// File: rtl/core_iencode.sv
// RV32I encoder and program loader: packs decoded field sets into instruction words
// and writes them sequentially into IMEM from a programmed base address.
module core_iencode #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic          CLK,
  input  logic          RST,
  core_iencode_if.slave bus
);

  localparam logic [3:0] C_R     = 4'd0;
  localparam logic [3:0] C_I_ALU = 4'd1;
  localparam logic [3:0] C_LOAD  = 4'd2;
  localparam logic [3:0] C_S     = 4'd3;
  localparam logic [3:0] C_B     = 4'd4;
  localparam logic [3:0] C_JAL   = 4'd5;
  localparam logic [3:0] C_JALR  = 4'd6;
  localparam logic [3:0] C_LUI   = 4'd7;
  localparam logic [3:0] C_AUIPC = 4'd8;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        ill;
    logic [31:0] word;
  } enc_t;

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_FINISH} state_t;

  // Illegal field sets collapse to a NOP so later slots keep their addresses.
  function automatic enc_t encode(
    input logic [3:0]         cls,
    input logic [2:0]         f3,
    input logic [6:0]         f7,
    input logic [4:0]         rd,
    input logic [4:0]         rs1,
    input logic [4:0]         rs2,
    input logic signed [31:0] imm
  );
    enc_t r;
    logic ok;
    logic i_fit;
    logic b_fit;
    logic j_fit;
    logic u_fit;
    logic shift;
    i_fit  = (&imm[31:11]) | ~(|imm[31:11]);
    b_fit  = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
    j_fit  = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
    u_fit  = ~(|imm[11:0]);
    shift  = (f3 == 3'b001) || (f3 == 3'b101);
    r.word = NOP;
    ok     = 1'b0;
    case (cls)
      C_R: begin
        r.word = {f7, rs2, rs1, f3, rd, OP_R};
        ok     = 1'b1;
      end
      C_I_ALU: begin
        if (shift) begin
          r.word = {f7, imm[4:0], rs1, f3, rd, OP_I_ALU};
          ok     = ~(|imm[31:5]);
        end else begin
          r.word = {imm[11:0], rs1, f3, rd, OP_I_ALU};
          ok     = i_fit;
        end
      end
      C_LOAD: begin
        r.word = {imm[11:0], rs1, f3, rd, OP_LOAD};
        ok     = i_fit;
      end
      C_JALR: begin
        r.word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        ok     = i_fit;
      end
      C_S: begin
        r.word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
        ok     = i_fit;
      end
      C_B: begin
        r.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
        ok     = b_fit;
      end
      C_JAL: begin
        r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        ok     = j_fit;
      end
      C_LUI: begin
        r.word = {imm[31:12], rd, OP_LUI};
        ok     = u_fit;
      end
      C_AUIPC: begin
        r.word = {imm[31:12], rd, OP_AUIPC};
        ok     = u_fit;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) r.word = NOP;
    r.ill = ~ok;
    return r;
  endfunction

  state_t            state;
  state_t            state_nx;
  enc_t              enc_p0;
  logic [31:0]       wdata_p1;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  idx;
  logic              err;
  logic [CNT_W-1:0]  err_idx;
  logic              start_go;
  logic              accept;
  logic              write_fire;

  assign start_go   = (state == S_IDLE) && bus.START;
  assign accept     = (state == S_ACCEPT) && bus.IN_VALID;
  assign write_fire = (state == S_WRITE) && bus.MEM_WREADY;

  assign enc_p0 = encode(bus.OPCLASS, bus.FUNCT3, bus.FUNCT7, bus.RD, bus.RS1,
                         bus.RS2, bus.IMM);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.IN_READY   = 1'b0;
    bus.MEM_WVALID = 1'b0;
    bus.DONE       = 1'b0;
    bus.BUSY       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.START) state_nx = (bus.COUNT == '0) ? S_FINISH : S_ACCEPT;
      end
      S_ACCEPT: begin
        bus.IN_READY = 1'b1;
        bus.BUSY     = 1'b1;
        if (bus.IN_VALID) state_nx = S_WRITE;
      end
      S_WRITE: begin
        bus.MEM_WVALID = 1'b1;
        bus.BUSY       = 1'b1;
        if (bus.MEM_WREADY)
          state_nx = (remaining == CNT_W'(1)) ? S_FINISH : S_ACCEPT;
      end
      S_FINISH: begin
        bus.DONE = 1'b1;
        bus.BUSY = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Encode stage -> write stage: the word is registered on accept and held through WRITE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr      <= '0;
      remaining <= '0;
      idx       <= '0;
      wdata_p1  <= '0;
      err       <= 1'b0;
      err_idx   <= '0;
    end else begin
      if (start_go) begin
        addr      <= bus.BASE_ADDR & ~ADDR_W'(3);
        remaining <= bus.COUNT;
        idx       <= '0;
        err       <= 1'b0;
        err_idx   <= '0;
      end
      if (accept) begin
        wdata_p1 <= enc_p0.word;
        if (enc_p0.ill) begin
          err <= 1'b1;
          if (!err) err_idx <= idx;
        end
      end
      if (write_fire) begin
        addr      <= addr + ADDR_W'(4);
        remaining <= remaining - CNT_W'(1);
        idx       <= idx + CNT_W'(1);
      end
    end
  end

  assign bus.MEM_WADDR = addr;
  assign bus.MEM_WDATA = wdata_p1;
  assign bus.ERR       = err;
  assign bus.ERR_IDX   = err_idx;

endmodule

// File: tb/tb_core_iencode.sv
// Bench for core_iencode: directed sessions from the test plan plus randomized sessions
// checked against an arithmetic reference encoder.
module tb_core_iencode;

  logic CLK;
  logic RST;

  core_iencode_if #(.ADDR_W(32), .CNT_W(16)) ifc ();

  core_iencode #(.ADDR_W(32), .CNT_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  typedef struct {
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    int          stall;
  } fs_t;

  fs_t items[$];
  int  total = 0;
  int  bad   = 0;
  int  wr_cnt = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(posedge CLK)
    if (!RST && ifc.MEM_WVALID && ifc.MEM_WREADY) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bf(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference: legality by signed range arithmetic, words assembled by shifted field sums.
  function automatic logic [31:0] model(input fs_t f, output bit ill);
    longint      s;
    logic [31:0] w;
    logic [31:0] rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] f3;
    logic [31:0] f7;
    bit          ok;
    s   = longint'($signed(f.imm));
    rd  = 32'(f.rd) << 7;
    f3  = 32'(f.f3) << 12;
    rs1 = 32'(f.rs1) << 15;
    rs2 = 32'(f.rs2) << 20;
    f7  = 32'(f.f7) << 25;
    w   = 32'h13;
    ok  = 0;
    case (f.cls)
      4'd0: begin w = 32'h33 + rd + f3 + rs1 + rs2 + f7; ok = 1; end
      4'd1: begin
        if (f.f3 == 3'd1 || f.f3 == 3'd5) begin
          w  = 32'h13 + rd + f3 + rs1 + (bf(f.imm, 4, 0) << 20) + f7;
          ok = (f.imm < 32);
        end else begin
          w  = 32'h13 + rd + f3 + rs1 + (bf(f.imm, 11, 0) << 20);
          ok = (s >= -2048 && s <= 2047);
        end
      end
      4'd2: begin
        w  = 32'h03 + rd + f3 + rs1 + (bf(f.imm, 11, 0) << 20);
        ok = (s >= -2048 && s <= 2047);
      end
      4'd6: begin
        w  = 32'h67 + rd + rs1 + (bf(f.imm, 11, 0) << 20);
        ok = (s >= -2048 && s <= 2047);
      end
      4'd3: begin
        w  = 32'h23 + (bf(f.imm, 4, 0) << 7) + f3 + rs1 + rs2 + (bf(f.imm, 11, 5) << 25);
        ok = (s >= -2048 && s <= 2047);
      end
      4'd4: begin
        w  = 32'h63 + (bf(f.imm, 11, 11) << 7) + (bf(f.imm, 4, 1) << 8) + f3 + rs1 + rs2
             + (bf(f.imm, 10, 5) << 25) + (bf(f.imm, 12, 12) << 31);
        ok = (s % 2 == 0) && s >= -4096 && s <= 4095;
      end
      4'd5: begin
        w  = 32'h6F + rd + (bf(f.imm, 19, 12) << 12) + (bf(f.imm, 11, 11) << 20)
             + (bf(f.imm, 10, 1) << 21) + (bf(f.imm, 20, 20) << 31);
        ok = (s % 2 == 0) && s >= -(64'sd1 <<< 20) && s < (64'sd1 <<< 20);
      end
      4'd7: begin w = (f.imm & 32'hFFFFF000) + rd + 32'h37; ok = (f.imm % 4096 == 0); end
      4'd8: begin w = (f.imm & 32'hFFFFF000) + rd + 32'h17; ok = (f.imm % 4096 == 0); end
      default: ok = 0;
    endcase
    ill = !ok;
    return ok ? w : 32'h0000_0013;
  endfunction

  function automatic fs_t mk(input logic [3:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm, input int stall);
    fs_t f;
    f.cls = cls; f.f3 = f3; f.f7 = f7; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2;
    f.imm = imm; f.stall = stall;
    return f;
  endfunction

  function automatic fs_t rnd_item();
    fs_t         f;
    int          w;
    logic [31:0] v;
    f.cls = ($urandom % 12 == 0) ? 4'(9 + $urandom % 7) : 4'($urandom % 9);
    f.f3  = 3'($urandom); f.f7 = 7'($urandom);
    f.rd  = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
    case ($urandom % 5)
      0: w = 5;
      1: w = 12;
      2: w = 13;
      3: w = 21;
      default: w = 32;
    endcase
    v = $urandom;
    f.imm = (w < 32) ? 32'($signed(v << (32 - w)) >>> (32 - w)) : v;
    if ($urandom % 2 == 1) f.imm[0] = 1'b0;
    if ((f.cls == 4'd7 || f.cls == 4'd8) && ($urandom % 4 != 0)) f.imm[11:0] = 12'h0;
    f.stall = $urandom % 4;
    return f;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_session(input logic [31:0] base, input bit poke);
    int          n;
    int          w0;
    int          k;
    logic [31:0] exp_addr;
    logic [31:0] exp_word;
    bit          ill;
    bit          m_err;
    int          m_idx;
    n        = items.size();
    w0       = wr_cnt;
    exp_addr = base & ~32'd3;
    m_err    = 0;
    m_idx    = 0;
    ifc.START = 1'b1; ifc.BASE_ADDR = base; ifc.COUNT = 16'(n);
    tick();
    ifc.START = 1'b0;
    chk("err_clear_on_start", 32'(ifc.ERR), 32'd0);
    chk("err_idx_clear_on_start", 32'(ifc.ERR_IDX), 32'd0);
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!ifc.IN_READY && k < 10) begin tick(); k++; end
      chk("in_ready_accept", 32'(ifc.IN_READY), 32'd1);
      chk("busy_accept", 32'(ifc.BUSY), 32'd1);
      ifc.OPCLASS = items[i].cls; ifc.FUNCT3 = items[i].f3; ifc.FUNCT7 = items[i].f7;
      ifc.RD = items[i].rd; ifc.RS1 = items[i].rs1; ifc.RS2 = items[i].rs2;
      ifc.IMM = items[i].imm; ifc.IN_VALID = 1'b1;
      if (poke && i == 0) begin
        ifc.START = 1'b1; ifc.BASE_ADDR = ~base; ifc.COUNT = 16'd7;
      end
      tick();
      ifc.IN_VALID = 1'b0; ifc.START = 1'b0;
      exp_word = model(items[i], ill);
      if (ill && !m_err) begin m_err = 1; m_idx = i; end
      chk("wvalid_after_accept", 32'(ifc.MEM_WVALID), 32'd1);
      chk("waddr", ifc.MEM_WADDR, exp_addr);
      chk("wdata", ifc.MEM_WDATA, exp_word);
      chk("in_ready_write", 32'(ifc.IN_READY), 32'd0);
      for (int j = 0; j < items[i].stall; j++) begin
        tick();
        chk("wvalid_stall", 32'(ifc.MEM_WVALID), 32'd1);
        chk("waddr_stall", ifc.MEM_WADDR, exp_addr);
        chk("wdata_stall", ifc.MEM_WDATA, exp_word);
        chk("in_ready_stall", 32'(ifc.IN_READY), 32'd0);
      end
      ifc.MEM_WREADY = 1'b1;
      tick();
      ifc.MEM_WREADY = 1'b0;
      exp_addr += 4;
    end
    chk("done_pulse", 32'(ifc.DONE), 32'd1);
    chk("wvalid_finish", 32'(ifc.MEM_WVALID), 32'd0);
    chk("err_end", 32'(ifc.ERR), 32'(m_err));
    chk("err_idx_end", 32'(ifc.ERR_IDX), 32'(m_idx));
    tick();
    chk("done_one_cycle", 32'(ifc.DONE), 32'd0);
    chk("busy_idle", 32'(ifc.BUSY), 32'd0);
    chk("write_count", 32'(wr_cnt - w0), 32'(n));
    chk("err_hold", 32'(ifc.ERR), 32'(m_err));
  endtask

  initial begin
    int w0;
    RST = 1'b1;
    ifc.START = 1'b0; ifc.BASE_ADDR = '0; ifc.COUNT = '0; ifc.IN_VALID = 1'b0;
    ifc.OPCLASS = '0; ifc.FUNCT3 = '0; ifc.FUNCT7 = '0; ifc.RD = '0; ifc.RS1 = '0;
    ifc.RS2 = '0; ifc.IMM = '0; ifc.MEM_WREADY = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(ifc.IN_READY), 32'd0);
    chk("rst_wvalid", 32'(ifc.MEM_WVALID), 32'd0);
    chk("rst_waddr", ifc.MEM_WADDR, 32'd0);
    chk("rst_wdata", ifc.MEM_WDATA, 32'd0);
    chk("rst_busy", 32'(ifc.BUSY), 32'd0);
    chk("rst_done", 32'(ifc.DONE), 32'd0);
    chk("rst_err", 32'(ifc.ERR), 32'd0);
    chk("rst_err_idx", 32'(ifc.ERR_IDX), 32'd0);
    RST = 1'b0;
    tick();

    // add x3,x1,x2 -> 0x002081B3
    items = {};
    items.push_back(mk(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0));
    chk("ref_add", model(items[0], w0[0]), 32'h002081B3);
    do_session(32'h100, 0);

    items = {};
    items.push_back(mk(4'd1, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 0));
    items.push_back(mk(4'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1));
    items.push_back(mk(4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 0));
    do_session(32'h100, 0);

    items = {};
    items.push_back(mk(4'd1, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3, 5));
    items.push_back(mk(4'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000, 0));
    items.push_back(mk(4'd5, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 2));
    do_session(32'h203, 1);

    // Illegal B at index 1, then an illegal LUI at index 2
    items = {};
    items.push_back(mk(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0));
    items.push_back(mk(4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 0));
    items.push_back(mk(4'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h123, 0));
    do_session(32'h100, 0);
    repeat (3) tick();
    chk("err_sticky_idle", 32'(ifc.ERR), 32'd1);
    chk("err_idx_sticky_idle", 32'(ifc.ERR_IDX), 32'd1);

    items = {};
    do_session(32'h400, 0);

    for (int s = 0; s < 10; s++) begin
      int n;
      n = $urandom % 7;
      items = {};
      for (int i = 0; i < n; i++) items.push_back(rnd_item());
      do_session($urandom, 1'($urandom));
    end

    // Reset while a write is pending
    items = {};
    w0 = wr_cnt;
    ifc.START = 1'b1; ifc.BASE_ADDR = 32'h800; ifc.COUNT = 16'd2;
    tick();
    ifc.START = 1'b0;
    ifc.OPCLASS = 4'd0; ifc.RD = 5'd3; ifc.RS1 = 5'd1; ifc.RS2 = 5'd2;
    ifc.FUNCT3 = 3'd0; ifc.FUNCT7 = 7'd0; ifc.IN_VALID = 1'b1;
    tick();
    ifc.IN_VALID = 1'b0;
    chk("rstw_wvalid_before", 32'(ifc.MEM_WVALID), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstw_wvalid_after", 32'(ifc.MEM_WVALID), 32'd0);
    chk("rstw_busy_after", 32'(ifc.BUSY), 32'd0);
    chk("rstw_in_ready_after", 32'(ifc.IN_READY), 32'd0);
    ifc.MEM_WREADY = 1'b1;
    repeat (4) tick();
    ifc.MEM_WREADY = 1'b0;
    chk("rstw_no_writes", 32'(wr_cnt - w0), 32'd0);
    chk("rstw_done_none", 32'(ifc.DONE), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
